reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 111 +++++++++++
 tb/tb_reg_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: fourteen DATA_W-bit registers R1..R14 with one one-hot write port,
// two registered read ports with write-first forwarding, a sticky flag for
// multi-bit write selects and a saturating count of accepted writes.
// Addresses 0 and 15 have no storage behind them and read as zero.

module reg_bank #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [13:0]       wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              sel_err,
    output logic [7:0]        wr_count
);

    localparam int NREG = 14;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic              sel_err_q, sel_err_d;
    logic [7:0]        wr_count_q, wr_count_d;

    logic sel_any;
    logic sel_multi;
    logic wr_accept;
    logic wr_bad;

    // Classify the write select: clearing the lowest set bit leaves a
    // non-zero value only when two or more bits were set.
    always_comb begin
        sel_any   = |wr_sel;
        sel_multi = |(wr_sel & (wr_sel - 14'd1));
        wr_accept = wr_en && sel_any && !sel_multi;
        wr_bad    = wr_en && sel_multi;
    end

    // Next register contents; only an accepted (exactly one-hot) write lands.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_accept && wr_sel[i]) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Read muxes look at the next-state array so a same-edge write is forwarded.
    always_comb begin
        rd_data_a_d = '0;
        rd_data_b_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_addr_a == 4'(i + 1)) begin
                rd_data_a_d = regs_d[i];
            end
            if (rd_addr_b == 4'(i + 1)) begin
                rd_data_b_d = regs_d[i];
            end
        end
    end

    // Sticky error flag (a new bad write beats err_clr) and saturating counter.
    always_comb begin
        sel_err_d = sel_err_q;
        if (wr_bad) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end

        wr_count_d = wr_count_q;
        if (wr_accept && (wr_count_q != 8'hFF)) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            sel_err_q   <= 1'b0;
            wr_count_q  <= 8'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            sel_err_q   <= sel_err_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign sel_err   = sel_err_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed tests for reg_bank, one task per scenario.

module tb_reg_bank;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [13:0] wr_sel;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        err_clr;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        sel_err;
    logic [7:0]  wr_count;

    int errors = 0;
    int checks = 0;

    reg_bank #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .err_clr   (err_clr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .sel_err   (sel_err),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || sel_err !== 1'b0 || wr_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h err=%b cnt=%0d required all 0",
                     rd_data_a, rd_data_b, sel_err, wr_count);
        end
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_sel = 14'b00_0000_0000_0100; wr_data = 16'hA5A5;
        tick();
        wr_en = 1'b0; wr_sel = '0; rd_addr_a = 4'd3;
        tick();
        checks++;
        if (rd_data_a !== 16'hA5A5) begin
            errors++;
            $display("FAIL write_read_r3: got %h required a5a5", rd_data_a);
        end
        checks++;
        if (wr_count !== 8'd1) begin
            errors++;
            $display("FAIL write_read_count: got %0d required 1", wr_count);
        end
    endtask

    task automatic test_all_regs();
        logic [15:0] exp;
        for (int n = 1; n <= 14; n++) begin
            wr_en = 1'b1; wr_sel = 14'(1) << (n - 1); wr_data = 16'h0100 + 16'(n);
            tick();
        end
        wr_en = 1'b0; wr_sel = '0;
        for (int n = 0; n <= 15; n++) begin
            rd_addr_a = 4'(n); rd_addr_b = 4'(n);
            tick();
            exp = (n == 0 || n == 15) ? 16'h0000 : 16'h0100 + 16'(n);
            checks++;
            if (rd_data_a !== exp || rd_data_b !== exp) begin
                errors++;
                $display("FAIL all_regs_addr%0d: got a=%h b=%h required %h", n, rd_data_a, rd_data_b, exp);
            end
        end
        checks++;
        if (wr_count !== 8'd15) begin
            errors++;
            $display("FAIL all_regs_count: got %0d required 15", wr_count);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_sel = 14'b00_0000_0100_0000; wr_data = 16'h1234;
        rd_addr_b = 4'd7; rd_addr_a = 4'd6;
        tick();
        wr_en = 1'b0; wr_sel = '0;
        checks++;
        if (rd_data_b !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_r7: got %h required 1234", rd_data_b);
        end
        checks++;
        if (rd_data_a !== 16'h0106) begin
            errors++;
            $display("FAIL bypass_neighbour_r6: got %h required 0106", rd_data_a);
        end
    endtask

    task automatic test_bad_select();
        wr_en = 1'b1; wr_sel = 14'b00_0000_0000_0011; wr_data = 16'hFFFF;
        tick();
        wr_en = 1'b0; wr_sel = '0;
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_sel_flag: got %b required 1", sel_err);
        end
        checks++;
        if (wr_count !== 8'd16) begin
            errors++;
            $display("FAIL bad_sel_count: got %0d required 16", wr_count);
        end
        rd_addr_a = 4'd1; rd_addr_b = 4'd2;
        tick();
        checks++;
        if (rd_data_a !== 16'h0101 || rd_data_b !== 16'h0102) begin
            errors++;
            $display("FAIL bad_sel_regs: got r1=%h r2=%h required 0101 0102", rd_data_a, rd_data_b);
        end
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_sel_sticky: got %b required 1", sel_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_sel_clear: got %b required 0", sel_err);
        end
        wr_en = 1'b1; wr_sel = 14'b11_0000_0000_0000; wr_data = 16'hDEAD; err_clr = 1'b1;
        tick();
        wr_en = 1'b0; wr_sel = '0; err_clr = 1'b0;
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_sel_clr_collide: got %b required 1", sel_err);
        end
        rd_addr_a = 4'd13; rd_addr_b = 4'd14;
        tick();
        checks++;
        if (rd_data_a !== 16'h010D || rd_data_b !== 16'h010E) begin
            errors++;
            $display("FAIL bad_sel_r13_r14: got %h %h required 010d 010e", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_null_and_idle();
        // null write: sel_err stays 1 (still set), count unchanged
        wr_en = 1'b1; wr_sel = '0; wr_data = 16'h5555;
        tick();
        checks++;
        if (sel_err !== 1'b1 || wr_count !== 8'd16) begin
            errors++;
            $display("FAIL null_write: got err=%b cnt=%0d required 1 16", sel_err, wr_count);
        end
        // wr_en low with a valid select: no write
        wr_en = 1'b0; wr_sel = 14'b00_0000_0001_0000; wr_data = 16'hBEEF; rd_addr_a = 4'd5;
        tick();
        wr_sel = '0;
        checks++;
        if (rd_data_a !== 16'h0105 || wr_count !== 8'd16) begin
            errors++;
            $display("FAIL idle_no_write: got r5=%h cnt=%0d required 0105 16", rd_data_a, wr_count);
        end
    endtask

    task automatic test_saturation();
        rd_addr_a = 4'd14;
        for (int i = 0; i < 260; i++) begin
            wr_en = 1'b1; wr_sel = 14'b10_0000_0000_0000; wr_data = 16'(i);
            tick();
            if (i == 237) begin
                checks++;
                if (wr_count !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_254: got %0d required 254", wr_count);
                end
            end
            if (i == 238) begin
                checks++;
                if (wr_count !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_255: got %0d required 255", wr_count);
                end
            end
        end
        checks++;
        if (wr_count !== 8'd255 || rd_data_a !== 16'd259) begin
            errors++;
            $display("FAIL sat_end: got cnt=%0d r14=%h required 255 0103", wr_count, rd_data_a);
        end
        wr_sel = '0;
        tick();
        wr_en = 1'b0;
        checks++;
        if (wr_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_null: got %0d required 255", wr_count);
        end
    endtask

    task automatic test_mid_reset();
        rd_addr_a = 4'd14; rd_addr_b = 4'd1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_sel = 14'(1) << i; wr_data = 16'hC000 + 16'(i);
            tick();
        end
        // reset asserts between edges while the burst is still driving
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || sel_err !== 1'b0 || wr_count !== 8'h0) begin
            errors++;
            $display("FAIL mid_reset_async: got a=%h b=%h err=%b cnt=%0d required all 0",
                     rd_data_a, rd_data_b, sel_err, wr_count);
        end
        wr_sel = 14'b00_0000_0010_0000; err_clr = 1'b1;
        tick();
        checks++;
        if (rd_data_a !== 16'h0 || wr_count !== 8'h0) begin
            errors++;
            $display("FAIL mid_reset_held: got a=%h cnt=%0d required 0 0", rd_data_a, wr_count);
        end
        wr_en = 1'b0; wr_sel = '0; err_clr = 1'b0;
        #2 rst_n = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            rd_addr_a = 4'(n); rd_addr_b = 4'(15 - n);
            tick();
            checks++;
            if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
                errors++;
                $display("FAIL post_reset_addr%0d: got a=%h b=%h required 0000", n, rd_data_a, rd_data_b);
            end
        end
        checks++;
        if (wr_count !== 8'h0 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_state: got cnt=%0d err=%b required 0 0", wr_count, sel_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_all_regs();
        test_bypass();
        test_bad_select();
        test_null_and_idle();
        test_saturation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
